neuron_event_merge_fifo: RTL

//  - Multi-channel successor to the single-neuron event FIFO: NUM_CH independent per-neuron score queues.
//  - A round-robin arbiter merges the queues onto one registered output stream tagged with the source neuron ID.
//  - Sits between the LIF neuron array (score producers) and the shared downstream event consumer.

---
 rtl/neuron_event_pkg.sv | 20 ++
 rtl/event_ch_fifo.sv | 64 ++++++
 rtl/neuron_event_merge_fifo.sv | 121 ++++++++++++
 3 files changed

// File: rtl/neuron_event_pkg.sv
// Shared definitions for the neuron event merge path: default widths, ID width helper
// and the {id, score} event record layout used by consumers of out_id/out_score.
package neuron_event_pkg;

    localparam int SCORE_W_DEF = 4;
    localparam int NUM_CH_DEF  = 4;
    localparam int DEPTH_DEF   = 4;

    function automatic int id_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    localparam int ID_W_DEF = id_width(NUM_CH_DEF);

    typedef struct packed {
        logic [ID_W_DEF-1:0]    id;
        logic [SCORE_W_DEF-1:0] score;
    } neuron_event_t;

endpackage

// File: rtl/event_ch_fifo.sv
// Single-channel circular score queue: DEPTH x SCORE_W storage, wrapping rd/wr pointers,
// occupancy count and head data. Push into a full queue and pop from an empty queue are ignored.
module event_ch_fifo
    import neuron_event_pkg::*;
#(
    parameter  int SCORE_W = SCORE_W_DEF,
    parameter  int DEPTH   = DEPTH_DEF,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [SCORE_W-1:0] din,
    output logic [SCORE_W-1:0] head,
    output logic [AW:0]        count
);

    logic [SCORE_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [AW:0]        count_r;
    logic               full_s;
    logic               empty_s;
    logic               push_ok_s;
    logic               pop_ok_s;

    // Qualify requests against current occupancy.
    always_comb begin
        full_s    = (count_r == (AW+1)'(DEPTH));
        empty_s   = (count_r == {(AW+1){1'b0}});
        push_ok_s = push && !full_s;
        pop_ok_s  = pop && !empty_s;
    end

    // Storage, pointers and count; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {SCORE_W{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/neuron_event_merge_fifo.sv
// Merges NUM_CH per-neuron score queues onto one registered, ID-tagged stream via round robin.
// Optional feature macro: NEURON_EVENT_LEVEL_EN adds the per-channel fifo_level output.
module neuron_event_merge_fifo
    import neuron_event_pkg::*;
#(
    parameter  int SCORE_W = SCORE_W_DEF,
    parameter  int NUM_CH  = NUM_CH_DEF,
    parameter  int DEPTH   = DEPTH_DEF,
    localparam int ID_W    = id_width(NUM_CH),
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         score_valid,
    input  logic [NUM_CH*SCORE_W-1:0] score_in,
    output logic [NUM_CH-1:0]         score_ready,
    output logic                      out_valid,
    output logic [SCORE_W-1:0]        out_score,
    output logic [ID_W-1:0]           out_id,
    input  logic                      out_ready,
    output logic [NUM_CH-1:0]         fifo_full,
    output logic [NUM_CH-1:0]         fifo_empty
`ifdef NEURON_EVENT_LEVEL_EN
    ,
    output logic [NUM_CH*(AW+1)-1:0]  fifo_level
`endif
);

    logic [SCORE_W-1:0] head_s  [NUM_CH];
    logic [AW:0]        count_s [NUM_CH];
    logic [NUM_CH-1:0]  full_s;
    logic [NUM_CH-1:0]  empty_s;
    logic [NUM_CH-1:0]  push_s;
    logic [NUM_CH-1:0]  pop_s;
    logic               load_s;
    logic               grant_found_s;
    logic [ID_W-1:0]    grant_id_s;
    logic [ID_W-1:0]    rr_ptr_r;
    logic               out_valid_r;
    logic [SCORE_W-1:0] out_score_r;
    logic [ID_W-1:0]    out_id_r;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        event_ch_fifo #(
            .SCORE_W (SCORE_W),
            .DEPTH   (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push_s[c]),
            .pop   (pop_s[c]),
            .din   (score_in[c*SCORE_W +: SCORE_W]),
            .head  (head_s[c]),
            .count (count_s[c])
        );
`ifdef NEURON_EVENT_LEVEL_EN
        assign fifo_level[c*(AW+1) +: AW+1] = count_s[c];
`endif
    end

    // Queue status; ready depends only on stored state, so a full queue blocks even when popped.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            full_s[c]  = (count_s[c] == (AW+1)'(DEPTH));
            empty_s[c] = (count_s[c] == {(AW+1){1'b0}});
            push_s[c]  = score_valid[c] && !full_s[c];
        end
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = {ID_W{1'b0}};
        for (int i = 1; i <= NUM_CH; i++) begin
            logic [ID_W-1:0] cand_v;
            cand_v = ID_W'((int'(rr_ptr_r) + i) % NUM_CH);
            if (!grant_found_s && !empty_s[cand_v]) begin
                grant_found_s = 1'b1;
                grant_id_s    = cand_v;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Pop the granted head only when the output register is free to load.
    always_comb begin
        load_s = !out_valid_r || out_ready;
        pop_s  = {NUM_CH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            pop_s[c] = load_s && grant_found_s && (grant_id_s == ID_W'(c));
        end
    end

    // Output register and RR pointer; ch0 wins first after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_score_r <= {SCORE_W{1'b0}};
            out_id_r    <= {ID_W{1'b0}};
            rr_ptr_r    <= ID_W'(NUM_CH - 1);
        end else if (load_s) begin
            if (grant_found_s) begin
                out_valid_r <= 1'b1;
                out_score_r <= head_s[grant_id_s];
                out_id_r    <= grant_id_s;
                rr_ptr_r    <= grant_id_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign score_ready = ~full_s;
    assign fifo_full   = full_s;
    assign fifo_empty  = empty_s;
    assign out_valid   = out_valid_r;
    assign out_score   = out_score_r;
    assign out_id      = out_id_r;

endmodule
